// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer.
// master: the sequencer (takes control inputs, drives PCin/fetch_en/fetch_count/state/fault).
// slave : the consumer/driver on the other side (drives stall/redirect/halt_req).
interface pc_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             halt_req;
    logic [31:0]      PCin;
    logic             fetch_en;
    logic [CNT_W-1:0] fetch_count;
    logic [1:0]       state;
    logic             fault;

    modport master (
        input  stall, redirect, redirect_pc, halt_req,
        output PCin, fetch_en, fetch_count, state, fault
    );

    modport slave (
        output stall, redirect, redirect_pc, halt_req,
        input  PCin, fetch_en, fetch_count, state, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding the instruction-fetch stage.
// Ports: clk, rst_n (synchronous, active-low), bus (pc_sequencer_if.master):
//   stall/redirect/redirect_pc/halt_req in; PCin, fetch_en, fetch_count, state, fault out.
// PCin starts at ENTRY_PC, advances by 4, follows aligned redirects, halts on
// halt_req, on a misaligned redirect (sticky fault) or after MAX_FETCH advances.
module pc_sequencer #(
    parameter logic [31:0] ENTRY_PC  = 32'h0000_0028,
    parameter int unsigned MAX_FETCH = 0,
    parameter int unsigned CNT_W     = 32
) (
    input logic            clk,
    input logic            rst_n,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t           st;
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;
    logic             flt;

    logic [CNT_W-1:0] cnt_inc;
    logic             budget_hit;
    logic             misaligned;

    // Saturating advance count; budget is judged on the post-advance value
    assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign budget_hit = (MAX_FETCH != 0) && (cnt_inc == CNT_W'(MAX_FETCH));
    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

    // Sequencer state, PC and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= BOOT;
            pc  <= ENTRY_PC;
            cnt <= '0;
            flt <= 1'b0;
        end else begin
            case (st)
                BOOT: st <= RUN;
                RUN, STALL: begin
                    if (bus.halt_req) begin
                        st <= HALT;
                    end else if (bus.redirect && misaligned) begin
                        st  <= HALT;
                        flt <= 1'b1;
                    end else if (bus.redirect) begin
                        // redirect takes precedence over stall
                        pc  <= bus.redirect_pc;
                        cnt <= cnt_inc;
                        st  <= budget_hit ? HALT : RUN;
                    end else if (bus.stall) begin
                        st <= STALL;
                    end else if (st == RUN) begin
                        pc  <= pc + 32'd4;
                        cnt <= cnt_inc;
                        st  <= budget_hit ? HALT : RUN;
                    end else begin
                        // leaving STALL re-presents the held PC once
                        st <= RUN;
                    end
                end
                default: st <= HALT;
            endcase
        end
    end

    assign bus.PCin        = pc;
    assign bus.fetch_count = cnt;
    assign bus.state       = st;
    assign bus.fault       = flt;
    assign bus.fetch_en    = (st == RUN) || (st == STALL);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver pushes hand-computed expected
// outputs per edge into a queue; a monitor pops and compares after each edge.
module tb_pc_sequencer;
    localparam logic [1:0] SB = 2'd0;
    localparam logic [1:0] SR = 2'd1;
    localparam logic [1:0] SS = 2'd2;
    localparam logic [1:0] SH = 2'd3;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        flt;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   n_checks;
    int   n_pass;
    int   vec;

    pc_sequencer_if #(.CNT_W(32)) bus ();

    pc_sequencer #(
        .ENTRY_PC (32'h0000_0028),
        .MAX_FETCH(11),
        .CNT_W    (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s vec%0d: got %h want %h", nm, idx, act, want);
    endtask

    // Drive one cycle of inputs and queue what the following edge must produce
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                        input logic h, input logic [31:0] epc, input logic [1:0] est,
                        input logic [31:0] ecnt, input logic eflt);
        exp_t e;
        @(negedge clk);
        rst_n           = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt_req    = h;
        e.idx = vec;
        e.pc  = epc;
        e.st  = est;
        e.cnt = ecnt;
        e.flt = eflt;
        q.push_back(e);
        vec++;
    endtask

    // Monitor: compare after every rising edge that has an expectation queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", e.idx, bus.PCin, e.pc);
                chk("state", e.idx, 32'(bus.state), 32'(e.st));
                chk("fetch_count", e.idx, bus.fetch_count, e.cnt);
                chk("fault", e.idx, 32'(bus.fault), 32'(e.flt));
                chk("fetch_en", e.idx, 32'(bus.fetch_en), 32'((e.st == SR) || (e.st == SS)));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vec      = 0;
        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt_req    = 1'b0;

        // Sequential run until the 11-advance budget halts
        step(0, 0, 0, 32'h0, 0, 32'h28, SB, 0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h28, SR, 0, 0);
        for (int i = 1; i <= 11; i++)
            step(1, 0, 0, 32'h0, 0, 32'h28 + 32'(4 * i), (i == 11) ? SH : SR, 32'(i), 0);
        step(1, 1, 0, 32'h0, 0, 32'h54, SH, 11, 0);
        step(1, 0, 1, 32'h200, 0, 32'h54, SH, 11, 0);
        step(1, 0, 0, 32'h0, 1, 32'h54, SH, 11, 0);
        step(1, 0, 0, 32'h0, 0, 32'h54, SH, 11, 0);
        step(1, 0, 0, 32'h0, 0, 32'h54, SH, 11, 0);

        // Reset out of HALT, then stall window at 0x30
        step(0, 0, 0, 32'h0, 0, 32'h28, SB, 0, 0);
        step(1, 1, 1, 32'h300, 1, 32'h28, SR, 0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h2C, SR, 1, 0);
        step(1, 0, 0, 32'h0, 0, 32'h30, SR, 2, 0);
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 32'h0, 0, 32'h30, SS, 2, 0);
        step(1, 0, 0, 32'h0, 0, 32'h30, SR, 2, 0);
        step(1, 0, 0, 32'h0, 0, 32'h34, SR, 3, 0);
        step(1, 0, 0, 32'h0, 0, 32'h38, SR, 4, 0);
        step(1, 0, 0, 32'h0, 0, 32'h3C, SR, 5, 0);
        step(1, 0, 0, 32'h0, 0, 32'h40, SR, 6, 0);

        // Redirect beats stall, then wrap at the top of the address space
        step(1, 1, 1, 32'h100, 0, 32'h100, SR, 7, 0);
        step(1, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, SR, 8, 0);
        step(1, 0, 0, 32'h0, 0, 32'h0, SR, 9, 0);

        // halt_req outranks redirect; no fault
        step(1, 0, 1, 32'h200, 1, 32'h0, SH, 9, 0);
        step(1, 0, 0, 32'h0, 0, 32'h0, SH, 9, 0);

        // Reset while in STALL
        step(0, 0, 0, 32'h0, 0, 32'h28, SB, 0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h28, SR, 0, 0);
        step(1, 1, 0, 32'h0, 0, 32'h28, SS, 0, 0);
        step(0, 1, 0, 32'h0, 0, 32'h28, SB, 0, 0);

        // Misaligned redirect: sticky fault, HALT ignores everything
        step(1, 0, 0, 32'h0, 0, 32'h28, SR, 0, 0);
        step(1, 0, 1, 32'h102, 0, 32'h28, SH, 0, 1);
        step(1, 0, 1, 32'h200, 0, 32'h28, SH, 0, 1);
        step(1, 0, 0, 32'h0, 1, 32'h28, SH, 0, 1);
        step(1, 1, 1, 32'h300, 0, 32'h28, SH, 0, 1);

        // Reset while HALTed with fault, then one advance
        step(0, 0, 0, 32'h0, 0, 32'h28, SB, 0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h28, SR, 0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h2C, SR, 1, 0);

        repeat (3) @(negedge clk);
        chk("queue_drain", vec, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
